// File: rtl/idwt_reconstruct.sv
// idwt_reconstruct: inverse single-level integer Haar lifting behind a pair FIFO.
// Define IDWT_SAT_EN to clamp samples to 16-bit range and report sat_event.
module idwt_reconstruct #(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] detail_coefficient,
  input  logic [15:0] coarse_coefficient,
  output logic        in_ready,
  output logic [15:0] data_out,
  output logic        valid_out,
  input  logic        out_ready,
  output logic        last_out,
  output logic        sat_event
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [AW:0]     PTR_ONE  = 1;
  localparam logic [CNTW-1:0] CNT_ONE  = 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FRAME_LEN - 1);

`ifdef IDWT_SAT_EN
  localparam int CW = 18;
`else
  localparam int CW = 16;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD} state_t;

  state_t state_q, state_d;

  logic [31:0]     mem_q [DEPTH];
  logic [AW:0]     wptr_q, rptr_q;
  logic            full, empty, push, pop;
  logic            ld_odd, odd_done;
  logic [15:0]     pair_det, pair_crs;
  logic [16:0]     odd_q;
  logic [15:0]     data_q;
  logic            sat_q;
  logic [CNTW-1:0] cnt_q;

  logic signed [CW-1:0] det_x, crs_x, even_x, odd_x;
  logic [16:0]          even_f, odd_f;

  // Extra pointer bit separates full from empty when the low bits match
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign in_ready = !full;
  assign push  = valid_in && !full;

  assign {pair_det, pair_crs} = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= {detail_coefficient, coarse_coefficient};
    end
  end

  assign det_x  = CW'($signed(pair_det));
  assign crs_x  = CW'($signed(pair_crs));
  assign even_x = crs_x - (det_x >>> 1);
  assign odd_x  = even_x + det_x;

`ifdef IDWT_SAT_EN
  function automatic logic [16:0] fit(input logic signed [CW-1:0] v);
    if (v > 18'sd32767) begin
      return {1'b1, 16'h7fff};
    end else if (v < -18'sd32768) begin
      return {1'b1, 16'h8000};
    end
    return {1'b0, v[15:0]};
  endfunction

  assign even_f = fit(even_x);
  assign odd_f  = fit(odd_x);
`else
  assign even_f = {1'b0, even_x};
  assign odd_f  = {1'b0, odd_x};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!empty) state_d = S_EVEN;
      S_EVEN: if (out_ready) state_d = S_ODD;
      S_ODD:  if (out_ready) state_d = empty ? S_IDLE : S_EVEN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    ld_odd   = 1'b0;
    odd_done = 1'b0;
    unique case (state_q)
      S_IDLE: pop = !empty;
      S_EVEN: ld_odd = out_ready;
      S_ODD: begin
        odd_done = out_ready;
        pop      = out_ready && !empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      odd_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      // A pop always loads the even sample and parks the odd one
      if (pop) begin
        data_q <= even_f[15:0];
        sat_q  <= even_f[16];
        odd_q  <= odd_f;
      end else if (ld_odd) begin
        data_q <= odd_q[15:0];
        sat_q  <= odd_q[16];
      end
      if (odd_done) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = (state_q != S_IDLE);
  assign last_out  = (state_q == S_ODD) && (cnt_q == CNT_LAST);
  assign sat_event = sat_q;
endmodule

// File: tb/tb_idwt_reconstruct.sv
// tb_idwt_reconstruct: scoreboard bench for the inverse Haar stage.
// Directed vectors push expected beats; a negedge monitor pops and compares.
module tb_idwt_reconstruct;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] det = '0;
  logic [15:0] crs = '0;
  logic        in_ready, valid_out, last_out, sat_event;
  logic [15:0] data_out;

  always #5 clk = ~clk;

  idwt_reconstruct #(.DEPTH(4), .FRAME_LEN(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_in           (valid_in),
    .detail_coefficient (det),
    .coarse_coefficient (crs),
    .in_ready           (in_ready),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .out_ready          (out_ready),
    .last_out           (last_out),
    .sat_event          (sat_event)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        sat;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int fails  = 0;
  int pairs  = 0;

  logic [15:0] bp_d [8] = '{16'd2, 16'hfffe, 16'd6, 16'd1,
                            16'h0100, 16'd8, 16'd0, 16'd4};
  logic [15:0] bp_c [8] = '{16'd10, 16'd0, 16'd100, 16'hfffb,
                            16'h0200, 16'd8, 16'd0, 16'd4};
  logic [15:0] bp_e [8] = '{16'd9, 16'd1, 16'd97, 16'hfffb,
                            16'h0180, 16'd4, 16'd0, 16'd2};
  logic [15:0] bp_o [8] = '{16'd11, 16'hffff, 16'd103, 16'hfffc,
                            16'h0280, 16'd12, 16'd0, 16'd6};

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
    end
  endfunction

  function automatic void push_pair(input logic [15:0] ev, od,
                                    input logic se, so);
    beat_t b;
    b.data = ev; b.last = 1'b0; b.sat = se;
    sb.push_back(b);
    b.data = od; b.last = ((pairs % 16) == 15); b.sat = so;
    sb.push_back(b);
    pairs++;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rst && valid_out && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat actual=%0h expected=none", data_out);
      end else begin
        e = sb.pop_front();
        checks--;
        chk("beat_data", data_out, e.data);
        chk("beat_last", last_out, e.last);
        chk("beat_sat", sat_event, e.sat);
      end
    end
  end

  task automatic send(input logic [15:0] d, c, ev, od, input logic se, so);
    bit ok;
    ok = 0;
    valid_in = 1'b1; det = d; crs = c;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push_pair(ev, od, se, so);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    chk("drain_left", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    pairs = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int idx;
    logic [15:0] e, o, d, c;

    do_reset();
    chk("rst_valid", valid_out, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", data_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_sat", sat_event, 0);

    // Two ramps 0..31 through the forward transform; last on pairs 15, 31
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      e = 16'((2 * k) % 32);
      o = e + 16'd1;
      d = o - e;
      c = e + 16'($signed(d) >>> 1);
      send(d, c, e, o, 1'b0, 1'b0);
    end
    drain();

    send(16'd4, 16'd10, 16'd8, 16'd12, 1'b0, 1'b0);
    chk("lat_not_yet", valid_out, 0);
    @(posedge clk); #1;
    chk("lat_even_valid", valid_out, 1);
    chk("lat_even_data", data_out, 16'd8);
    @(posedge clk); #1;
    chk("lat_odd_valid", valid_out, 1);
    chk("lat_odd_data", data_out, 16'd12);
    @(posedge clk); #1;
    chk("lat_done", valid_out, 0);
    drain();

    send(16'hfffd, 16'd5, 16'd7, 16'd4, 1'b0, 1'b0);
    drain();

`ifdef IDWT_SAT_EN
    send(16'h8000, 16'h7fff, 16'h7fff, 16'h3fff, 1'b1, 1'b0);
`else
    send(16'h8000, 16'h7fff, 16'hbfff, 16'h3fff, 1'b0, 1'b0);
`endif
    drain();

    // Backpressure: holding regs plus DEPTH FIFO slots
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (idx < 8) begin
        valid_in = 1'b1; det = bp_d[idx]; crs = bp_c[idx];
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk);
      if (valid_out) chk("bp_hold_data", data_out, 16'd9);
      if (valid_in && in_ready) begin
        push_pair(bp_e[idx], bp_o[idx], 1'b0, 1'b0);
        idx++;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    chk("bp_accepted", idx, 5);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", valid_out, 1);
    chk("bp_data", data_out, 16'd9);
    out_ready = 1'b1;
    drain();

    // Reset with one pair held and three buffered
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(bp_d[k], bp_c[k], bp_e[k], bp_o[k], 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_valid", valid_out, 1);
    do_reset();
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_last", last_out, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_stale", valid_out, 0);
    send(16'd0, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
    for (int k = 1; k < 16; k++) begin
      e = 16'(2 * k);
      send(16'd1, e, e, e + 16'd1, 1'b0, 1'b0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/idwt_reconstruct.md
Name: idwt_reconstruct

Overview:
- Inverse single-level integer Haar lifting stage, the synthesis counterpart of the forward DWT pipeline.
- Consumes (detail_coefficient, coarse_coefficient) pairs and rebuilds the original sample stream, even sample first, then odd, one sample per output beat.
- Buffers input pairs in a small internal FIFO and supports ready/valid backpressure on both sides.
- Sits downstream of the forward-DWT output or a coefficient store.

Parameters:
- DEPTH, 4, input pair FIFO depth (power of 2, >=2).
- FRAME_LEN, 16, coefficient pairs per frame; drives last_out.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- valid_in  input  1  input pair valid
- detail_coefficient  input  16  signed detail coefficient d
- coarse_coefficient  input  16  signed coarse coefficient c
- in_ready  output  1  pair FIFO can accept
- data_out  output  16  reconstructed sample
- valid_out  output  1  data_out valid
- out_ready  input  1  downstream accepts data_out
- last_out  output  1  final sample of frame (qualified by valid_out)
- sat_event  output  1  clamp occurred on current data_out (feature only, else 0)

Behaviour:
- Clock is one clock: clk. Reset is synchronous and active-high: rst. Port names clk and rst.
- Reset: FIFO emptied, FSM to IDLE, pair counter=0. Outputs: in_ready=1 (combinational !full), valid_out=0, data_out=0, last_out=0, sat_event=0.
- Reset mid-frame discards all buffered and in-flight data, with no partial output afterwards.
- Input handshake: pair accepted on an edge where valid_in && in_ready.
  - in_ready = !fifo_full; a pop in the same cycle does NOT free a slot for that cycle's push.
  - Inputs are ignored when in_ready=0.
- Arithmetic: 16-bit two's complement, arithmetic shift.
  - even = c - (d >>> 1)
  - odd = even + d, using the unwrapped even
  - Default is wrap modulo 2^16, which gives exact inverse of the forward stage.
- FSM:
  - IDLE: if FIFO non-empty, pop, compute even/odd into holding regs, load data_out=even, valid_out=1, go to EVEN.
  - EVEN: when out_ready, load data_out=odd, go to ODD; else hold.
  - ODD: when out_ready, if FIFO non-empty pop the next pair, load its even, go to EVEN (back-to-back, no bubble); else valid_out=0, go to IDLE.
- Output holds data_out/valid_out/last_out/sat_event stable while valid_out && !out_ready.
- Latency: pair accepted at edge T into an empty, idle block gives even valid after edge T+1 and odd one cycle later if out_ready=1.
- Throughput: 1 sample/cycle; sustained 1 pair per 2 cycles.
- Capacity: DEPTH pairs in FIFO plus 1 pair in holding regs.
- Pair counter increments on acceptance of each odd beat and wraps to 0 after FRAME_LEN-1.
  - last_out=1 only on the odd beat of pair index FRAME_LEN-1.
- FIFO pointers wrap modulo DEPTH; full/empty use an extra pointer bit.

Optional Feature:
- Macro IDWT_SAT_EN.
- Defined:
  - even and odd computed in 18-bit signed, odd from the unclamped 18-bit even.
  - Each result clamped to [-32768, 32767] at output.
  - sat_event=1 on any beat whose value was clamped.
- Undefined: wrap arithmetic; sat_event tied 0.

Test Plan:
- Single pair d=4, c=10, out_ready=1 -> data_out 8 then 12 on consecutive cycles, valid_out high 2 cycles starting 2 edges after acceptance.
- Negative d=0xFFFD (-3), c=5 -> even 7 (0x0007), odd 4 (0x0004).
- Overflow c=0x7FFF, d=0x8000:
  - without IDWT_SAT_EN -> 0xBFFF, 0x3FFF, sat_event=0.
  - with IDWT_SAT_EN -> 0x7FFF (sat_event=1), 0x3FFF (sat_event=0).
- Backpressure: out_ready=0, stream pairs with valid_in=1 -> exactly DEPTH+1=5 accepted, then in_ready=0, first even held stable. Release out_ready -> 10 samples in order, no loss/duplication.
- Frame: 2*FRAME_LEN=32 pairs, out_ready=1 -> last_out on sample 31 and 63 only; forward-DWT coefficients of ramp 0..31 reconstruct 0..31 exactly.
- Reset asserted while in EVEN with 3 pairs buffered -> next cycle valid_out=0, in_ready=1, counter 0. New pair d=0, c=1 -> outputs 1, 1 with no stale data.
